// File: rtl/smart_timer_pkg.sv
// Shared types and default parameters for the smart_timer countdown block.
package smart_timer_pkg;

    localparam int LEN_W_DEF          = 5;
    localparam int FLICKER_THRESH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

endpackage

// File: rtl/smart_timer_flicker.sv
// Registered warning toggle: flips on each enabled step whose count is inside the window.
module smart_timer_flicker #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [LEN_W-1:0] i_count,
    input  logic [LEN_W-1:0] i_thresh,
    output logic             o_flicker
);

    logic w_in_window;
    logic r_flicker;

    // Window test on the post-decrement count
    always_comb begin
        w_in_window = (i_count != {LEN_W{1'b0}}) && (i_count <= i_thresh);
    end

    // Toggle register; clear wins, and it holds while neither clear nor enable is active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flicker <= 1'b0;
        end else if (i_clr) begin
            r_flicker <= 1'b0;
        end else if (i_en) begin
            r_flicker <= w_in_window ? ~r_flicker : 1'b0;
        end else begin
            r_flicker <= r_flicker;
        end
    end

    assign o_flicker = r_flicker;

endmodule

// File: rtl/smart_timer.sv
// Programmable countdown timer with freeze, end-of-count flicker and a sticky done flag.
module smart_timer
    import smart_timer_pkg::*;
#(
    parameter int LEN_W          = LEN_W_DEF,
    parameter int FLICKER_THRESH = FLICKER_THRESH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_start,
    input  logic [LEN_W-1:0] t_length,
    input  logic             t_freeze,
    output logic             t_flicker,
    output logic             t_done
);

    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_flk_en;
    logic             w_flk_clr;
    logic             r_done;

    // Next-state and counter logic; start overrides freeze and expiry
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flk_en    = 1'b0;
        w_flk_clr   = 1'b0;
        if (t_start) begin
            w_count_nxt = t_length;
            w_flk_clr   = 1'b1;
            if (t_length == {LEN_W{1'b0}}) begin
                w_state_nxt = DONE;
            end else begin
                w_state_nxt = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (t_freeze) begin
                        w_state_nxt = FROZEN;
                    end else if (r_count > {LEN_W{1'b0}}) begin
                        w_count_nxt = r_count - LEN_W'(1);
                        w_flk_en    = 1'b1;
                        if (w_count_nxt == {LEN_W{1'b0}}) begin
                            w_state_nxt = DONE;
                            w_flk_clr   = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end else begin
                        w_state_nxt = DONE;
                        w_flk_clr   = 1'b1;
                    end
                end
                // Resuming costs one edge with no decrement
                FROZEN: begin
                    if (t_freeze) begin
                        w_state_nxt = FROZEN;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = {LEN_W{1'b0}};
                    w_flk_clr   = 1'b1;
                end
            endcase
        end
    end

    // State, count and done registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= {LEN_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= (w_state_nxt == DONE);
        end
    end

    smart_timer_flicker #(
        .LEN_W (LEN_W)
    ) u_flicker (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_flk_en),
        .i_clr     (w_flk_clr),
        .i_count   (w_count_nxt),
        .i_thresh  (LEN_W'(FLICKER_THRESH)),
        .o_flicker (t_flicker)
    );

    assign t_done = r_done;

endmodule

// File: tb/tb_smart_timer.sv
// Directed vector bench for smart_timer: table of per-cycle vectors plus reset corner sequences.
module tb_smart_timer;

    logic       clk;
    logic       reset;
    logic       t_start;
    logic [4:0] t_length;
    logic       t_freeze;
    logic       t_flicker;
    logic       t_done;

    int n_vec;
    int n_err;

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       freeze;
        logic       exp_done;
        logic       exp_flk;
    } vec_t;

    vec_t vecs[$];

    smart_timer dut (
        .clk       (clk),
        .reset     (reset),
        .t_start   (t_start),
        .t_length  (t_length),
        .t_freeze  (t_freeze),
        .t_flicker (t_flicker),
        .t_done    (t_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic [4:0] l, input logic f,
                       input logic d, input logic fl);
        vec_t v;
        v.start = s; v.len = l; v.freeze = f; v.exp_done = d; v.exp_flk = fl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic d, input logic fl);
        n_vec++;
        if (t_done !== d || t_flicker !== fl) begin
            n_err++;
            $display("FAIL %s: got done=%0b flicker=%0b, expected done=%0b flicker=%0b",
                     name, t_done, t_flicker, d, fl);
        end
    endtask

    task automatic step(input logic s, input logic [4:0] l, input logic f);
        t_start = s; t_length = l; t_freeze = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; t_start = 1'b0; t_length = 5'd0; t_freeze = 1'b0;

        // Freeze pulses in IDLE do nothing
        add(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        // L=10, no freeze: flicker on 4,3,2,1; done after 10th edge
        add(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        // L=10, freeze 3 cycles after 5 decrements: done 4 edges later
        add(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        // Restart while running: L=10, after 4 decrements restart with 6
        add(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        // L=0 with freeze in the same cycle: done immediately
        add(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        // Start with freeze wins; freeze inside the window holds flicker
        add(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 1'b0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].len, vecs[i].freeze);
            check($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_flk);
        end

        // Mid-count async reset with flicker high (count 4), then no resume
        step(1'b1, 5'd10, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 1'b0);
        check("pre_reset_flicker", 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 check("async_reset_clear", 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 5'd0, 1'b0);
        check("no_resume", 1'b0, 1'b0);

        // L=20 after reset: done exactly 20 edges after start
        step(1'b1, 5'd20, 1'b0);
        check("l20_start", 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 5'd0, 1'b0);
            if (i == 20) check("l20_done", 1'b1, 1'b0);
            else if (i == 16 || i == 18) check($sformatf("l20_e%0d", i), 1'b0, 1'b1);
            else check($sformatf("l20_e%0d", i), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smart_timer.md
# smart_timer

Programmable countdown timer with freeze and end-of-count warning. On a start pulse it loads a 5-bit length and counts down one per clock. Counting can be paused with a freeze input. In the last few counts it drives a flicker output, and it holds a done flag once the count expires. It is a leaf block used by game/UI control FSMs that need "wait N cycles, warn, then signal" behaviour.

## Interface
- Parameters:
- `LEN_W`, default 5: width of the length and counter.
- `FLICKER_THRESH`, default 4: remaining-count value at or below which flicker is active.
- Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is asynchronous and active-low. Low clears all state immediately.
- `t_start`, in, 1: start/restart request, sampled on the rising edge.
- `t_length`, in, LEN_W: timer length in cycles; sampled only when `t_start` is accepted.
- `t_freeze`, in, 1: pause counting while high.
- `t_flicker`, out, 1: registered warning toggle near the end of the count.
- `t_done`, out, 1: registered flag; high while the timer is expired.

## Operation
- States are `IDLE`, `RUN`, `FROZEN` and `DONE`. The reset state is `IDLE`.
- In reset, `count` is 0, `t_flicker` is 0 and `t_done` is 0.
- `t_start`=1 in any state, including `RUN`/`FROZEN`/`DONE`:
  - Loads `count`=`t_length` and clears `t_done` and `t_flicker`.
  - Enters `RUN`, or enters `DONE` directly if `t_length`==0.
  - `t_start` has priority over `t_freeze` and over expiry in the same cycle.
- `RUN`:
  - If `t_freeze`=1, go to `FROZEN`; `count` is held.
  - Otherwise `count` decrements by 1. When it decrements to 0, go to `DONE`.
- `FROZEN`:
  - `count` and `t_flicker` are held.
  - Return to `RUN` on the first edge where `t_freeze`=0. No decrement happens on that edge.
- `DONE`:
  - `t_done`=1 and `t_flicker`=0.
  - Stays in `DONE` until `t_start` or reset.
- `t_freeze` has no effect in `IDLE` or `DONE`.
- Flicker:
  - In `RUN`, `t_flicker` toggles on each unfrozen decrement edge while the post-decrement count is nonzero and ≤ `FLICKER_THRESH`.
  - Outside that window `t_flicker` is 0.
- Counter arithmetic is unsigned LEN_W-bit and never wraps: decrement occurs only when `count` > 0.

## Timing
- Let E0 be the edge that accepts `t_start` with length L > 0.
- `t_done` rises after edge E(L+F), where F is the number of cycles spent in `FROZEN` plus one return cycle per freeze episode. With no freeze, `t_done` is high in the cycle after the L-th edge following E0.
- With L==0, `t_done` is high after E0.
- Both outputs are flop outputs; there is no combinational path from inputs to outputs.
- Asserting reset mid-count returns to `IDLE` with outputs 0 immediately. The timer does not resume after reset deasserts.

## Structure
- Package `smart_timer_pkg` holds:
  - the state enum typedef `timer_state_t` (IDLE, RUN, FROZEN, DONE);
  - the constants `LEN_W` default and `FLICKER_THRESH` default.
- Top-level `smart_timer` contains the FSM and the down-counter.
- One sub-module `smart_timer_flicker` takes enable, count and threshold and produces the registered toggle.

## Test plan
- Hold reset low, then release. `t_done`=0, `t_flicker`=0, state `IDLE`. Freeze pulses do nothing.
- `t_length`=10 with a 1-cycle `t_start` and no freeze: `t_done` is 0 for 10 cycles, then 1 and held. `t_flicker` toggles on the decrements to 4, 3, 2, 1, then goes 0.
- `t_length`=10 with start, then `t_freeze` high for 3 cycles after 5 decrements: `count` holds at 5. `t_done` rises 4 cycles later than the no-freeze case.
- Assert reset while `count`≈3, release, then `t_length`=20 with start: outputs clear asynchronously. `t_done` rises 20 cycles after the new start edge.
- Restart while running (`t_length`=10, then after 4 decrements `t_start` with `t_length`=6): the new count of 6 is loaded. `t_done` rises 6 cycles after the restart edge.
- `t_length`=0 with start: `t_done`=1 the next cycle and `t_flicker` stays 0. A start with `t_freeze`=1 in the same cycle is still accepted.
